// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle between the upstream word source, the
// serializer and the downstream shift register.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] i_data;
    logic             i_valid;
    logic             o_ready;
    logic             o_sd;
    logic             o_sd_valid;
    logic             o_last;

    modport master (
        output i_data, i_valid,
        input  o_ready, o_sd, o_sd_valid, o_last
    );

    modport slave (
        input  i_data, i_valid,
        output o_ready, o_sd, o_sd_valid, o_last
    );
endinterface

// File: rtl/piso_serializer.sv
// MSB-first parallel-in serial-out transmitter with zero-gap streaming.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    piso_serializer_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sd_q;
    logic               sd_valid_q;
    logic               last_q;
    logic               fill_bit;
`ifdef PISO_PARITY_EN
    logic               par_q;
    // Parity is shifted in behind the data so it reaches the MSB exactly
    // once the last data bit has gone out.
    assign fill_bit = par_q;
`else
    assign fill_bit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            sd_q       <= 1'b0;
            sd_valid_q <= 1'b0;
            last_q     <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        state      <= SHIFT;
                        shift_q    <= bus.i_data;
                        cnt_q      <= LOAD_CNT;
                        sd_q       <= bus.i_data[WIDTH-1];
                        sd_valid_q <= 1'b1;
                        last_q     <= 1'b0;
`ifdef PISO_PARITY_EN
                        par_q      <= ^bus.i_data;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        if (bus.i_valid) begin
                            shift_q    <= bus.i_data;
                            cnt_q      <= LOAD_CNT;
                            sd_q       <= bus.i_data[WIDTH-1];
                            sd_valid_q <= 1'b1;
                            last_q     <= 1'b0;
`ifdef PISO_PARITY_EN
                            par_q      <= ^bus.i_data;
`endif
                        end else begin
                            state      <= IDLE;
                            shift_q    <= '0;
                            sd_q       <= 1'b0;
                            sd_valid_q <= 1'b0;
                            last_q     <= 1'b0;
                        end
                    end else begin
                        // Outputs are registered, so the next bit is taken
                        // one position below the current MSB.
                        shift_q <= {shift_q[WIDTH-2:0], fill_bit};
                        cnt_q   <= cnt_q - 1'b1;
                        sd_q    <= shift_q[WIDTH-2];
                        last_q  <= (cnt_q == CNT_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready    = (state == IDLE) || (cnt_q == '0);
    assign bus.o_sd       = sd_q;
    assign bus.o_sd_valid = sd_valid_q;
    assign bus.o_last     = last_q;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with a model of the downstream 4-bit
// shift register attached to o_sd.
module tb_piso_serializer;
`ifdef PISO_PARITY_EN
    localparam int F = 5;
`else
    localparam int F = 4;
`endif

    logic       i_clk;
    logic       i_rst;
    logic [3:0] o_q;
    int         checks;
    int         failures;

    piso_serializer_if #(.WIDTH(4)) bus ();

    piso_serializer #(.WIDTH(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always_ff @(posedge i_clk) o_q <= {o_q[2:0], bus.o_sd};

    typedef struct {
        logic [3:0] data;
        logic [4:0] bits;  // serial stream MSB first, then parity bit
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_sd"}, 32'(bus.o_sd), 0);
        chk({nm, "_sdv"}, 32'(bus.o_sd_valid), 0);
        chk({nm, "_last"}, 32'(bus.o_last), 0);
        chk({nm, "_rdy"}, 32'(bus.o_ready), 1);
    endtask

    task automatic send_one(input logic [3:0] w, input logic [4:0] exp, input string nm);
        bus.i_data  = w;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        for (int j = 0; j < F; j++) begin
            chk($sformatf("%s_sd%0d", nm, j), 32'(bus.o_sd), 32'(exp[4-j]));
            chk($sformatf("%s_sdv%0d", nm, j), 32'(bus.o_sd_valid), 1);
            chk($sformatf("%s_last%0d", nm, j), 32'(bus.o_last), 32'(j == F - 1));
            chk($sformatf("%s_rdy%0d", nm, j), 32'(bus.o_ready), 32'(j == F - 1));
            step();
        end
        chk_idle({nm, "_after"});
`ifndef PISO_PARITY_EN
        chk({nm, "_oq"}, 32'(o_q), 32'(w));
`endif
    endtask

    // Second word is presented from cycle raise_at onward; exp holds the
    // 2*F-bit stream right-justified, first bit in the highest position.
    task automatic two_words(input logic [3:0] w0, input logic [3:0] w1, input int raise_at,
                             input logic [9:0] exp, input string nm);
        bus.i_data  = w0;
        bus.i_valid = 1'b1;
        step();
        for (int c = 1; c <= 2 * F; c++) begin
            if (c > F) begin
                bus.i_valid = 1'b0;
                bus.i_data  = '0;
            end else if (c >= raise_at) begin
                bus.i_valid = 1'b1;
                bus.i_data  = w1;
            end else begin
                bus.i_valid = 1'b0;
                bus.i_data  = '0;
            end
            chk($sformatf("%s_sd%0d", nm, c), 32'(bus.o_sd), 32'(exp[2*F-c]));
            chk($sformatf("%s_sdv%0d", nm, c), 32'(bus.o_sd_valid), 1);
            chk($sformatf("%s_last%0d", nm, c), 32'(bus.o_last), 32'(c == F || c == 2 * F));
            chk($sformatf("%s_rdy%0d", nm, c), 32'(bus.o_ready), 32'(c == F || c == 2 * F));
            step();
        end
        chk_idle({nm, "_after"});
`ifndef PISO_PARITY_EN
        chk({nm, "_oq"}, 32'(o_q), 32'(w1));
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        o_q         = '0;
        bus.i_data  = '0;
        bus.i_valid = 1'b0;

        vecs[0] = '{4'b1011, 5'b10111};
        vecs[1] = '{4'b0110, 5'b01100};
        vecs[2] = '{4'b1001, 5'b10010};
        vecs[3] = '{4'b1100, 5'b11000};
        vecs[4] = '{4'b0001, 5'b00011};
        vecs[5] = '{4'b1111, 5'b11110};
        vecs[6] = '{4'b0000, 5'b00000};

        // Reset with i_valid high must be ignored.
        i_rst       = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = 4'b1111;
        #2;
        chk_idle("rst");
        step();
        step();
        chk_idle("rst_clk");
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        @(negedge i_clk);
        i_rst = 1'b1;

        step();
        for (int i = 0; i < 10; i++) chk_idle($sformatf("idle%0d", i));

        for (int v = 0; v < 7; v++) send_one(vecs[v].data, vecs[v].bits, $sformatf("vec%0d", v));

`ifdef PISO_PARITY_EN
        two_words(4'b1011, 4'b0110, 1, 10'b1011101100, "b2b");
        two_words(4'b1100, 4'b0011, 2, 10'b1100000110, "stall");
`else
        two_words(4'b1011, 4'b0110, 1, 10'b0010110110, "b2b");
        two_words(4'b1100, 4'b0011, 2, 10'b0011000011, "stall");
`endif

        // Abort mid-frame after two bits of 1010.
        bus.i_data  = 4'b1010;
        bus.i_valid = 1'b1;
        step();
        bus.i_valid = 1'b0;
        chk("abort_sd0", 32'(bus.o_sd), 1);
        step();
        chk("abort_sd1", 32'(bus.o_sd), 0);
        step();
        chk("abort_sdv2", 32'(bus.o_sd_valid), 1);
        #2;
        i_rst = 1'b0;
        #1;
        chk_idle("abort_async");
        step();
        chk_idle("abort_held");
        @(negedge i_clk);
        i_rst = 1'b1;
        step();
        chk_idle("abort_release");
        send_one(4'b0001, 5'b00011, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter that sits directly upstream of the 4-bit serial-in parallel-out shift register and drives its serial data input. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB first, one bit per clock. After WIDTH shifts, the downstream register's parallel output equals the accepted word, bit for bit. Back-to-back words stream with no idle cycle between them.

Parameters:
WIDTH, 4, word length in bits; legal range >= 2; must match the downstream register depth.

Ports:
i_clk  input  1  rising-edge clock, shared with the downstream shift register
i_rst  input  1  reset, asynchronous, active-low
i_data  input  WIDTH  parallel word to transmit
i_valid  input  1  i_data is valid; held until accepted
o_ready  output  1  serializer can accept a word this cycle
o_sd  output  1  serial data, MSB first; connects to the downstream D input
o_sd_valid  output  1  o_sd carries a frame bit this cycle
o_last  output  1  o_sd carries the final bit of the frame this cycle

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-low.
- Reset (i_rst low, asynchronous): state=IDLE, shift reg=0, bit counter=0, o_sd=0, o_sd_valid=0, o_last=0, o_ready=1.
- i_valid is ignored while i_rst is low.
- State machine, two states:
  - IDLE: o_ready=1, o_sd=0, o_sd_valid=0, o_last=0.
  - IDLE, on a clock edge with i_valid & o_ready: load shift reg <= i_data, counter <= WIDTH-1, go to SHIFT.
  - SHIFT: o_sd = shift reg[WIDTH-1], o_sd_valid=1.
  - SHIFT, each edge: shift reg shifts left by one with 0 filled in, counter decrements.
  - SHIFT, counter==0: o_last=1 and o_ready=1.
  - Last cycle, i_valid high at that edge: reload with i_data, counter <= WIDTH-1, stay in SHIFT (zero-gap streaming).
  - Last cycle, i_valid low at that edge: go to IDLE.
- o_ready = (state==IDLE) | (state==SHIFT & counter==0). It is combinational from registered state only, with no path from i_valid.
- Latency: word accepted at edge k. Bit i_data[WIDTH-1] is on o_sd during cycle k+1. Bit i_data[0] is on o_sd during cycle k+WIDTH, with o_last=1.
- Alignment: the downstream register holds the word after the edge that ends the o_last cycle.
- Counter width: $clog2(WIDTH+1) bits. The counter never wraps below 0; it is always reloaded or cleared at 0.
- i_valid while o_ready=0: no effect. The upstream must hold i_data stable until the handshake completes.
- Reset mid-frame: the frame is aborted immediately and outputs take their reset values. No partial frame is resumed after reset is released.
- All outputs except o_ready are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined: each frame is WIDTH+1 bits. The data bits are followed by one even-parity bit, ^i_data computed at load time and held in a register. The counter loads WIDTH. o_last and the ready-in-last-cycle behaviour move to the parity bit. Latency to the parity bit is k+WIDTH+1.
- Not defined: the frame is exactly WIDTH bits, there is no parity register, and behaviour is as described above.

Test Plan:
- WIDTH=4, i_data=4'b1011 accepted at edge 0 -> o_sd=1,0,1,1 in cycles 1-4. o_sd_valid=1 in cycles 1-4. o_last=1 in cycle 4 only. The downstream register o_q=4'b1011 after edge 4. Back to IDLE with o_ready=1 in cycle 5.
- Back-to-back 4'b1011 then 4'b0110 with i_valid held -> o_sd=1,0,1,1,0,1,1,0 in cycles 1-8 with no gap. o_last=1 in cycles 4 and 8. o_q=4'b0110 after edge 8.
- 4'b1100 accepted, then a new i_valid=1 with 4'b0011 raised in cycle 2 -> not accepted until the cycle-4 edge (o_ready=0 in cycles 1-3). Bits 0,0,1,1 appear in cycles 5-8.
- Reset pulse low mid-frame, after 2 bits of 4'b1010 -> o_sd=0, o_sd_valid=0, o_ready=1 asynchronously. After release, 4'b0001 is sent as 0,0,0,1 in full.
- i_valid=0 for 10 cycles after reset -> o_sd=0, o_sd_valid=0, o_last=0 throughout, o_ready=1 throughout.
- PISO_PARITY_EN defined, 4'b1011 -> o_sd=1,0,1,1,1 in cycles 1-5. o_last=1 in cycle 5. With 4'b1001 the parity bit is 0.
